// File: rtl/freq_divider_20bit.sv
// Free-running binary divider: /2^WIDTH square wave on MSB, selectable tap, terminal-count flag,
// MSB rising-edge pulse and a BLINK output toggling once per MSB period.
module freq_divider_20bit #(
    parameter int unsigned WIDTH = 20
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             CLR,
    input  logic [4:0]       TAP_SEL,
    output logic [WIDTH-1:0] COUNT,
    output logic             MSB,
    output logic             TAP_OUT,
    output logic             TC,
    output logic             MSB_RISE,
    output logic             BLINK
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_d;
    logic             r_msb_d;
    logic             r_blink;
    logic             w_blink_d;
    logic [31:0]      w_count_ext;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_count <= '0;
            r_msb_d <= 1'b0;
            r_blink <= 1'b0;
        end else begin
            r_count <= w_count_d;
            r_msb_d <= r_count[WIDTH-1];
            r_blink <= w_blink_d;
        end
    end

    always_comb begin
        w_count_d = r_count;
        if (CLR) begin
            w_count_d = '0;
        end else if (EN) begin
            w_count_d = r_count + WIDTH'(1);
        end
    end

    always_comb begin
        w_blink_d = r_blink;
        if (MSB_RISE) begin
            w_blink_d = ~r_blink;
        end
    end

    // Zero-extend so any TAP_SEL at or above WIDTH reads a constant 0.
    assign w_count_ext = 32'(r_count);

    assign COUNT    = r_count;
    assign MSB      = r_count[WIDTH-1];
    assign TAP_OUT  = w_count_ext[TAP_SEL];
    assign TC       = (&r_count) & EN & ~CLR;
    assign MSB_RISE = r_count[WIDTH-1] & ~r_msb_d;
    assign BLINK    = r_blink;

endmodule

// File: tb/tb_freq_divider_20bit.sv
// Self-checking bench: two widths (4 and 8) share stimulus and are compared against an
// arithmetic reference model, with directed checks for reset, schedules and EN/CLR priority.
module tb_freq_divider_20bit;

    localparam int unsigned W0 = 4;
    localparam int unsigned W1 = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          clr = 1'b0;
    logic [4:0]    tap_sel = '0;

    logic [W0-1:0] c0;
    logic          msb0, tap0, tc0, rise0, blink0;
    logic [W1-1:0] c1;
    logic          msb1, tap1, tc1, rise1, blink1;

    int unsigned   n_vec = 0;
    int unsigned   n_err = 0;

    longint unsigned m_count [2];
    bit              m_msbd  [2];
    bit              m_blink [2];
    int unsigned     m_w     [2];

    always #5 clk = ~clk;

    freq_divider_20bit #(.WIDTH(W0)) u_dut0 (
        .CLOCK(clk), .RESET(rst_n), .EN(en), .CLR(clr), .TAP_SEL(tap_sel),
        .COUNT(c0), .MSB(msb0), .TAP_OUT(tap0), .TC(tc0), .MSB_RISE(rise0), .BLINK(blink0)
    );

    freq_divider_20bit #(.WIDTH(W1)) u_dut1 (
        .CLOCK(clk), .RESET(rst_n), .EN(en), .CLR(clr), .TAP_SEL(tap_sel),
        .COUNT(c1), .MSB(msb1), .TAP_OUT(tap1), .TC(tc1), .MSB_RISE(rise1), .BLINK(blink1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_msb(input int i);
        return m_count[i] >= (64'd1 << (m_w[i] - 1));
    endfunction

    function automatic bit model_tap(input int i, input int unsigned sel);
        if (sel >= m_w[i]) return 1'b0;
        return ((m_count[i] >> sel) % 2) == 1;
    endfunction

    function automatic bit model_tc(input int i);
        return (m_count[i] == (64'd1 << m_w[i]) - 1) && en && !clr;
    endfunction

    function automatic bit model_rise(input int i);
        return model_msb(i) && !m_msbd[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_count[i] = 0;
            m_msbd[i]  = 1'b0;
            m_blink[i] = 1'b0;
        end
    endtask

    task automatic check_outputs();
        check_eq("count0", 64'(c0), m_count[0]);
        check_eq("msb0", 64'(msb0), 64'(model_msb(0)));
        check_eq("tap0", 64'(tap0), 64'(model_tap(0, tap_sel)));
        check_eq("tc0", 64'(tc0), 64'(model_tc(0)));
        check_eq("rise0", 64'(rise0), 64'(model_rise(0)));
        check_eq("blink0", 64'(blink0), 64'(m_blink[0]));
        check_eq("count1", 64'(c1), m_count[1]);
        check_eq("msb1", 64'(msb1), 64'(model_msb(1)));
        check_eq("tap1", 64'(tap1), 64'(model_tap(1, tap_sel)));
        check_eq("tc1", 64'(tc1), 64'(model_tc(1)));
        check_eq("rise1", 64'(rise1), 64'(model_rise(1)));
        check_eq("blink1", 64'(blink1), 64'(m_blink[1]));
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (model_rise(i)) m_blink[i] = !m_blink[i];
            m_msbd[i] = model_msb(i);
            if (clr) m_count[i] = 0;
            else if (en) m_count[i] = (m_count[i] + 1) % (64'd1 << m_w[i]);
        end
        #1;
    endtask

    // Apply inputs away from the edge, check against the model, then take one edge.
    task automatic cycle(input logic e, input logic c, input logic [4:0] sel);
        en = e;
        clr = c;
        tap_sel = sel;
        #1;
        check_outputs();
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        clr = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int first_rise1;
        int second_rise1;
        logic blink_before;

        m_w[0] = W0;
        m_w[1] = W1;
        model_reset();

        // Reset state.
        do_reset();
        check_outputs();
        check_eq("reset_count0", 64'(c0), 64'd0);
        check_eq("reset_blink0", 64'(blink0), 64'd0);

        // Free-run from reset: count sequence, blink schedule, first rise at width 8.
        first_rise1 = 0;
        second_rise1 = 0;
        for (int k = 1; k <= 400; k++) begin
            cycle(1'b1, 1'b0, 5'd0);
            if (k <= 64) begin
                check_eq("seq_count0", 64'(c0), 64'(k % 16));
                check_eq("blink_sched", 64'(blink0),
                         64'((k >= 9 && k < 25) || (k >= 41 && k < 57)));
            end
            if (rise1 === 1'b1) begin
                if (first_rise1 == 0) first_rise1 = k;
                else if (second_rise1 == 0) second_rise1 = k;
            end
        end
        check_eq("w8_first_rise", 64'(first_rise1), 64'd128);
        check_eq("w8_msb_period", 64'(second_rise1 - first_rise1), 64'd256);

        // EN/CLR priority.
        do_reset();
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 5'd1);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 5'd1);
            check_eq("hold_count", 64'(c0), 64'd6);
            check_eq("hold_tc", 64'(tc0), 64'd0);
        end
        cycle(1'b1, 1'b1, 5'd1);
        check_eq("clr_count", 64'(c0), 64'd0);
        for (int k = 0; k < 15; k++) cycle(1'b1, 1'b0, 5'd3);
        check_eq("at15_count", 64'(c0), 64'd15);
        blink_before = blink0;
        en = 1'b1;
        clr = 1'b1;
        #1;
        check_eq("clr_tc", 64'(tc0), 64'd0);
        check_outputs();
        step();
        check_eq("clr15_count", 64'(c0), 64'd0);
        check_eq("clr15_blink", 64'(blink0), 64'(blink_before));

        // MSB_RISE lasts one cycle even when EN holds COUNT at half-scale.
        do_reset();
        for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, 5'd2);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 5'd2);

        // Tap select sweeps.
        do_reset();
        for (int k = 0; k < 20; k++) cycle(1'b1, 1'b0, 5'd0);
        for (int k = 0; k < 20; k++) cycle(1'b1, 1'b0, 5'd2);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 1'b0, 5'd7);
            check_eq("tap7_zero", 64'(tap0), 64'd0);
        end

        // Randomized run.
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0),
                  5'($urandom_range(0, 31)));
        end

        // Asynchronous reset between edges after counting to 9.
        do_reset();
        for (int k = 0; k < 9; k++) cycle(1'b1, 1'b0, 5'd0);
        check_eq("pre_async_count", 64'(c0), 64'd9);
        en = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("async_count", 64'(c0), 64'd0);
        check_eq("async_msb", 64'(msb0), 64'd0);
        check_eq("async_tap", 64'(tap0), 64'd0);
        check_eq("async_tc", 64'(tc0), 64'd0);
        check_eq("async_rise", 64'(rise0), 64'd0);
        check_eq("async_blink", 64'(blink1), 64'd0);
        check_eq("async_count1", 64'(c1), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/freq_divider_20bit.md
Name: freq_divider_20bit

Overview:
- Free-running binary ripple-free counter/divider clocked from the on-chip oscillator (OSCH, 2.08 MHz nominal).
- Produces a /2^WIDTH square wave on MSB (about 2 Hz at the default width), plus a selectable tap, a terminal-count flag, an MSB rising-edge pulse, and a toggling BLINK output at half the MSB rate (about 1 Hz).
- Sits between the oscillator and board-level LED/pin logic.
- The OSCH primitive is instantiated at top level and is not part of this block.

Parameters:
- WIDTH, 20, counter width in bits; legal range 2..32.

Ports:
- CLOCK, input, 1, rising-edge clock (oscillator output).
- RESET, input, 1, asynchronous, active-low reset.
- EN, input, 1, count enable; 1 = increment each clock.
- CLR, input, 1, synchronous clear; priority over EN.
- TAP_SEL, input, 5, selects the counter bit driven onto TAP_OUT.
- COUNT, output, WIDTH, current counter value.
- MSB, output, 1, COUNT[WIDTH-1]; divided-by-2^WIDTH square wave.
- TAP_OUT, output, 1, COUNT[TAP_SEL].
- TC, output, 1, terminal count / wrap-imminent flag.
- MSB_RISE, output, 1, one-cycle pulse on MSB 0->1.
- BLINK, output, 1, toggles once per MSB period.

Behaviour:
- One clock domain (CLOCK). RESET is asynchronous, active-low.
- While RESET=0, all state clears immediately, independent of CLOCK: COUNT=0, internal msb_d=0, BLINK=0. Consequently MSB=0, TAP_OUT=0, TC=0, MSB_RISE=0.
- Release of RESET is not synchronized inside the block; the top level guarantees release away from clock edges.
- COUNT update at each rising CLOCK edge while RESET=1:
  - CLR=1: COUNT<=0, regardless of EN.
  - CLR=0, EN=1: COUNT<=COUNT+1 modulo 2^WIDTH (all-ones wraps to 0).
  - CLR=0, EN=0: COUNT holds.
- MSB = COUNT[WIDTH-1], taken directly from the register bit (glitch-free).
  - With EN held at 1: period 2^WIDTH clocks, 50% duty.
  - First rise occurs 2^(WIDTH-1) edges after reset release.
- TAP_OUT = COUNT[TAP_SEL] when TAP_SEL < WIDTH; 0 when TAP_SEL >= WIDTH. Combinational.
- TC = (COUNT == all-ones) & EN & ~CLR. Combinational; high exactly in the cycle before a wrap.
- msb_d is a register that samples MSB every clock edge, independent of EN.
- MSB_RISE = MSB & ~msb_d (combinational).
  - High for exactly one clock cycle: the first cycle in which COUNT == 2^(WIDTH-1).
  - If EN=0 holds COUNT at that value, the pulse still lasts only one cycle.
- BLINK register: BLINK <= ~BLINK on each rising edge where MSB_RISE=1; otherwise holds.
  - Period 2^(WIDTH+1) clocks with EN held at 1.
  - First goes high at edge 2^(WIDTH-1)+1 after reset release.
- CLR mid-count: COUNT returns to 0 at the next edge, so MSB falls if it was high. BLINK is not cleared.
- RESET asserted mid-operation clears everything, including BLINK, asynchronously.
- At default WIDTH=20 with a 2.08 MHz clock: MSB ≈ 1.98 Hz, BLINK ≈ 0.99 Hz.
  - The oscillator is inaccurate; no downstream logic relies on exact frequency.

Test Plan:
- Async reset: WIDTH=4, count to 9, drive RESET=0 between clock edges -> COUNT, MSB, TAP_OUT, TC, MSB_RISE and BLINK all 0 immediately, before the next edge.
- Free-run wrap: WIDTH=4, EN=1, CLR=0 from reset:
  - COUNT = 0,1,...,15,0 on successive edges.
  - TC=1 only while COUNT=15.
  - MSB=1 for COUNT 8..15.
  - MSB_RISE=1 only during the first cycle with COUNT=8.
- BLINK: WIDTH=4, 64 edges from reset with EN=1 -> BLINK toggles to 1 at edge 9, 0 at edge 25, 1 at edge 41, 0 at edge 57 (period 32).
- EN/CLR priority: WIDTH=4, COUNT=6:
  - EN=0 for 3 edges -> COUNT stays 6, TC=0.
  - Then CLR=1 with EN=1 -> COUNT=0 next edge.
  - CLR=1 while COUNT=15 -> TC=0 and COUNT=0, no BLINK change.
- Tap select: WIDTH=4, EN=1:
  - TAP_SEL=0 -> TAP_OUT toggles every clock.
  - TAP_SEL=2 -> TAP_OUT period 8 clocks.
  - TAP_SEL=7 -> TAP_OUT constant 0.
- Default width: WIDTH=20, EN=1 -> first MSB rise after 524288 edges, MSB period 1048576 edges, BLINK first rises at edge 524289.
